// File: rtl/ibex_fetch_realigner.sv
// ibex_fetch_realigner: splits 32-bit fetch words into RV32I/RV32C instructions,
// joins 32-bit instructions straddling two words, expands compressed encodings
// and queues the results (with PC and flags) for the ID stage.
// Optional build macro IBEX_REALIGN_PERF_EN adds the straddle_cnt_o counter.
module ibex_fetch_realigner #(
   parameter int unsigned DEPTH     = 2,
   parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        fetch_valid_i,
   output logic        fetch_ready_o,
   input  logic [31:0] fetch_rdata_i,
   input  logic        fetch_err_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_addr_i,
   output logic        instr_valid_o,
   input  logic        instr_ready_i,
   output logic [31:0] instr_o,
   output logic [31:0] instr_raw_o,
   output logic [31:0] pc_o,
   output logic        is_compressed_o,
   output logic        illegal_c_o,
   output logic        fetch_err_o
`ifdef IBEX_REALIGN_PERF_EN
   ,
   output logic [15:0] straddle_cnt_o
`endif
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef enum logic {RUN, ERR} state_e;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] raw;
      logic [31:0] pc;
      logic        comp;
      logic        ill;
      logic        err;
   } entry_t;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, wr1_ptr;
   logic               res_vld_q, res_vld_d;
   logic [15:0]        res_q, res_d;
   logic               skip_lo_q, skip_lo_d;
   logic [31:0]        pc_q, pc_d;
   entry_t             mem_q [DEPTH];
   entry_t             e0, e1, head;
   logic [1:0]         n_push;
   logic               fire, pop, h_pending;
   logic [31:0]        addr;
   logic [15:0]        lo_hw, hi_hw;
   logic               unused_redirect_addr0;

   assign unused_redirect_addr0 = redirect_addr_i[0];

   // RV32C to RV32I expansion; returns {illegal, instruction}
   function automatic logic [32:0] expand_c(input logic [15:0] c);
      logic [31:0] i;
      logic        ill;
      i   = '0;
      ill = 1'b0;
      case (c[1:0])
         2'b00: begin
            case (c[15:13])
               3'b000: begin
                  i   = {2'b0, c[10:7], c[12:11], c[5], c[6], 2'b00, 5'h02, 3'b000, 2'b01, c[4:2], 7'h13};
                  ill = (c[12:5] == 8'h00);
               end
               3'b010: i = {5'b0, c[5], c[12:10], c[6], 2'b00, 2'b01, c[9:7], 3'b010, 2'b01, c[4:2], 7'h03};
               3'b110: i = {5'b0, c[5], c[12], 2'b01, c[4:2], 2'b01, c[9:7], 3'b010, c[11:10], c[6], 2'b00, 7'h23};
               default: ill = 1'b1;
            endcase
         end
         2'b01: begin
            case (c[15:13])
               3'b000: i = {{6{c[12]}}, c[12], c[6:2], c[11:7], 3'b000, c[11:7], 7'h13};
               3'b001, 3'b101:
                  i = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], {9{c[12]}}, 4'b0, ~c[15], 7'h6f};
               3'b010: i = {{6{c[12]}}, c[12], c[6:2], 5'b0, 3'b000, c[11:7], 7'h13};
               3'b011: begin
                  if (c[11:7] == 5'h02) begin
                     i = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0, 5'h02, 3'b000, 5'h02, 7'h13};
                  end else begin
                     i = {{15{c[12]}}, c[6:2], c[11:7], 7'h37};
                  end
                  ill = ({c[12], c[6:2]} == 6'h00);
               end
               3'b100: begin
                  case (c[11:10])
                     2'b00, 2'b01: begin
                        i   = {1'b0, c[10], 5'b0, c[6:2], 2'b01, c[9:7], 3'b101, 2'b01, c[9:7], 7'h13};
                        ill = c[12];
                     end
                     2'b10: i = {{6{c[12]}}, c[12], c[6:2], 2'b01, c[9:7], 3'b111, 2'b01, c[9:7], 7'h13};
                     default: begin
                        case (c[6:5])
                           2'b00:   i = {7'b0100000, 2'b01, c[4:2], 2'b01, c[9:7], 3'b000, 2'b01, c[9:7], 7'h33};
                           2'b01:   i = {7'b0000000, 2'b01, c[4:2], 2'b01, c[9:7], 3'b100, 2'b01, c[9:7], 7'h33};
                           2'b10:   i = {7'b0000000, 2'b01, c[4:2], 2'b01, c[9:7], 3'b110, 2'b01, c[9:7], 7'h33};
                           default: i = {7'b0000000, 2'b01, c[4:2], 2'b01, c[9:7], 3'b111, 2'b01, c[9:7], 7'h33};
                        endcase
                        ill = c[12];
                     end
                  endcase
               end
               default:
                  i = {{4{c[12]}}, c[6:5], c[2], 5'b0, 2'b01, c[9:7], 2'b00, c[13], c[11:10], c[4:3], c[12], 7'h63};
            endcase
         end
         2'b10: begin
            case (c[15:13])
               3'b000: begin
                  i   = {7'b0, c[6:2], c[11:7], 3'b001, c[11:7], 7'h13};
                  ill = c[12];
               end
               3'b010: begin
                  i   = {4'b0, c[3:2], c[12], c[6:4], 2'b00, 5'h02, 3'b010, c[11:7], 7'h03};
                  ill = (c[11:7] == 5'h00);
               end
               3'b100: begin
                  if (!c[12]) begin
                     if (c[6:2] != 5'h00) begin
                        i = {7'b0, c[6:2], 5'b0, 3'b000, c[11:7], 7'h33};
                     end else begin
                        i   = {12'b0, c[11:7], 3'b000, 5'b0, 7'h67};
                        ill = (c[11:7] == 5'h00);
                     end
                  end else if (c[6:2] != 5'h00) begin
                     i = {7'b0, c[6:2], c[11:7], 3'b000, c[11:7], 7'h33};
                  end else if (c[11:7] == 5'h00) begin
                     i = 32'h0010_0073;
                  end else begin
                     i = {12'b0, c[11:7], 3'b000, 5'b00001, 7'h67};
                  end
               end
               3'b110: i = {4'b0, c[8:7], c[12], c[6:2], 5'h02, 3'b010, c[11:9], 2'b00, 7'h23};
               default: ill = 1'b1;
            endcase
         end
         default: ill = 1'b1;
      endcase
      if (ill) begin
         i = {16'h0000, c};
      end
      return {ill, i};
   endfunction

   function automatic entry_t make_c(input logic [15:0] c, input logic [31:0] pc);
      entry_t      e;
      logic [32:0] x;
      x       = expand_c(c);
      e.instr = x[31:0];
      e.raw   = {16'h0000, c};
      e.pc    = pc;
      e.comp  = 1'b1;
      e.ill   = x[32];
      e.err   = 1'b0;
      return e;
   endfunction

   function automatic entry_t make_w(input logic [31:0] w, input logic [31:0] pc);
      entry_t e;
      e.instr = w;
      e.raw   = w;
      e.pc    = pc;
      e.comp  = 1'b0;
      e.ill   = 1'b0;
      e.err   = 1'b0;
      return e;
   endfunction

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign lo_hw         = fetch_rdata_i[15:0];
   assign hi_hw         = fetch_rdata_i[31:16];
   assign fetch_ready_o = (state_q == RUN) && (cnt_q <= CNT_W'(DEPTH - 2));
   assign fire          = fetch_valid_i & fetch_ready_o & ~redirect_i;
   assign pop           = instr_valid_o & instr_ready_i & ~redirect_i;

   // Split the accepted word into up to two queue entries and update residue/pc/state
   always_comb begin
      e0        = '0;
      e1        = '0;
      n_push    = 2'd0;
      h_pending = 1'b0;
      addr      = pc_q;
      state_d   = state_q;
      res_vld_d = res_vld_q;
      res_d     = res_q;
      skip_lo_d = skip_lo_q;
      pc_d      = pc_q;
      if (redirect_i) begin
         state_d   = RUN;
         res_vld_d = 1'b0;
         skip_lo_d = redirect_addr_i[1];
         pc_d      = {redirect_addr_i[31:1], 1'b0};
      end else if (fire) begin
         if (fetch_err_i) begin
            // pc_q is the residue pc when a residue is held, else the current pc
            e0        = '{instr: 32'h0, raw: 32'h0, pc: pc_q, comp: 1'b0, ill: 1'b0, err: 1'b1};
            n_push    = 2'd1;
            res_vld_d = 1'b0;
            state_d   = ERR;
         end else begin
            h_pending = 1'b1;
            if (res_vld_q) begin
               e0        = make_w({lo_hw, res_q}, pc_q);
               n_push    = 2'd1;
               res_vld_d = 1'b0;
               addr      = pc_q + 32'd4;
            end else if (skip_lo_q) begin
               skip_lo_d = 1'b0;
            end else if (lo_hw[1:0] != 2'b11) begin
               e0     = make_c(lo_hw, pc_q);
               n_push = 2'd1;
               addr   = pc_q + 32'd2;
            end else begin
               e0        = make_w(fetch_rdata_i, pc_q);
               n_push    = 2'd1;
               addr      = pc_q + 32'd4;
               h_pending = 1'b0;
            end
            if (h_pending) begin
               if (hi_hw[1:0] != 2'b11) begin
                  if (n_push == 2'd0) begin
                     e0 = make_c(hi_hw, addr);
                  end else begin
                     e1 = make_c(hi_hw, addr);
                  end
                  n_push = n_push + 2'd1;
                  addr   = addr + 32'd2;
               end else begin
                  res_vld_d = 1'b1;
                  res_d     = hi_hw;
               end
            end
            pc_d = addr;
         end
      end
   end

   // Queue occupancy and pointer next-state; redirect empties the queue
   always_comb begin
      wr1_ptr  = ptr_inc(wr_ptr_q);
      cnt_d    = cnt_q + CNT_W'(n_push) - CNT_W'(pop);
      rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      case (n_push)
         2'd1:    wr_ptr_d = wr1_ptr;
         2'd2:    wr_ptr_d = ptr_inc(wr1_ptr);
         default: wr_ptr_d = wr_ptr_q;
      endcase
      if (redirect_i) begin
         cnt_d    = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
      end
   end

   // Control state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= RUN;
         cnt_q     <= '0;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         res_vld_q <= 1'b0;
         skip_lo_q <= BOOT_ADDR[1];
         pc_q      <= {BOOT_ADDR[31:1], 1'b0};
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         res_vld_q <= res_vld_d;
         skip_lo_q <= skip_lo_d;
         pc_q      <= pc_d;
      end
   end

   // Entry storage and residue halfword; contents are qualified by the control state
   always_ff @(posedge clk_i) begin
      res_q <= res_d;
      if (n_push != 2'd0) begin
         mem_q[wr_ptr_q] <= e0;
      end
      if (n_push == 2'd2) begin
         mem_q[wr1_ptr] <= e1;
      end
   end

   assign head            = mem_q[rd_ptr_q];
   assign instr_valid_o   = (cnt_q != '0);
   assign instr_o         = instr_valid_o ? head.instr : 32'h0;
   assign instr_raw_o     = instr_valid_o ? head.raw   : 32'h0;
   assign pc_o            = instr_valid_o ? head.pc    : 32'h0;
   assign is_compressed_o = instr_valid_o & head.comp;
   assign illegal_c_o     = instr_valid_o & head.ill;
   assign fetch_err_o     = instr_valid_o & head.err;

`ifdef IBEX_REALIGN_PERF_EN
   logic        straddle;
   logic [15:0] straddle_cnt_q;

   assign straddle = fire & ~fetch_err_i & res_vld_q;

   // Saturating count of instructions joined from a residue and the next word
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         straddle_cnt_q <= 16'h0000;
      end else if (redirect_i) begin
         straddle_cnt_q <= 16'h0000;
      end else if (straddle && (straddle_cnt_q != 16'hFFFF)) begin
         straddle_cnt_q <= straddle_cnt_q + 16'h0001;
      end
   end

   assign straddle_cnt_o = straddle_cnt_q;
`endif

endmodule

// File: tb/tb_ibex_fetch_realigner.sv
// Directed bench for ibex_fetch_realigner: vector table plus multi-cycle sequences.
module tb_ibex_fetch_realigner;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        fetch_valid_i = 1'b0;
   logic        fetch_ready_o;
   logic [31:0] fetch_rdata_i = '0;
   logic        fetch_err_i = 1'b0;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_addr_i = '0;
   logic        instr_valid_o;
   logic        instr_ready_i = 1'b0;
   logic [31:0] instr_o;
   logic [31:0] instr_raw_o;
   logic [31:0] pc_o;
   logic        is_compressed_o;
   logic        illegal_c_o;
   logic        fetch_err_o;
`ifdef IBEX_REALIGN_PERF_EN
   logic [15:0] straddle_cnt_o;
`endif

   int checks = 0;
   int failures = 0;

   ibex_fetch_realigner #(.DEPTH(DEPTH), .BOOT_ADDR(32'h0000_0080)) dut (
      .clk_i           (clk),
      .rst_ni          (rst_ni),
      .fetch_valid_i   (fetch_valid_i),
      .fetch_ready_o   (fetch_ready_o),
      .fetch_rdata_i   (fetch_rdata_i),
      .fetch_err_i     (fetch_err_i),
      .redirect_i      (redirect_i),
      .redirect_addr_i (redirect_addr_i),
      .instr_valid_o   (instr_valid_o),
      .instr_ready_i   (instr_ready_i),
      .instr_o         (instr_o),
      .instr_raw_o     (instr_raw_o),
      .pc_o            (pc_o),
      .is_compressed_o (is_compressed_o),
      .illegal_c_o     (illegal_c_o),
      .fetch_err_o     (fetch_err_o)
`ifdef IBEX_REALIGN_PERF_EN
      ,
      .straddle_cnt_o  (straddle_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic            redir;
      logic [31:0]     raddr;
      logic [31:0]     word;
      int              n;
      logic [1:0][31:0] e_instr;
      logic [1:0][31:0] e_raw;
      logic [1:0][31:0] e_pc;
      logic [1:0]      e_comp;
      logic [1:0]      e_ill;
   } vec_t;

   localparam int NVEC = 11;
   vec_t vecs [NVEC];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic set_vec(input int idx, input logic redir, input logic [31:0] raddr,
                          input logic [31:0] word, input int n,
                          input logic [31:0] i0, input logic [31:0] r0, input logic [31:0] p0,
                          input logic c0, input logic l0,
                          input logic [31:0] i1, input logic [31:0] r1, input logic [31:0] p1,
                          input logic c1, input logic l1);
      vecs[idx].redir      = redir;
      vecs[idx].raddr      = raddr;
      vecs[idx].word       = word;
      vecs[idx].n          = n;
      vecs[idx].e_instr[0] = i0;
      vecs[idx].e_raw[0]   = r0;
      vecs[idx].e_pc[0]    = p0;
      vecs[idx].e_comp[0]  = c0;
      vecs[idx].e_ill[0]   = l0;
      vecs[idx].e_instr[1] = i1;
      vecs[idx].e_raw[1]   = r1;
      vecs[idx].e_pc[1]    = p1;
      vecs[idx].e_comp[1]  = c1;
      vecs[idx].e_ill[1]   = l1;
   endtask

   task automatic do_redirect(input logic [31:0] addr);
      redirect_i      = 1'b1;
      redirect_addr_i = addr;
      @(negedge clk);
      redirect_i      = 1'b0;
   endtask

   task automatic send_word(input string name, input logic [31:0] w, input logic err);
      int t = 0;
      while (!fetch_ready_o && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk({name, ".ready_wait"}, {31'b0, fetch_ready_o}, 32'd1);
      fetch_valid_i = 1'b1;
      fetch_rdata_i = w;
      fetch_err_i   = err;
      @(negedge clk);
      fetch_valid_i = 1'b0;
      fetch_err_i   = 1'b0;
   endtask

   task automatic pop_check(input string name, input logic [31:0] ins, input logic [31:0] raw,
                            input logic [31:0] pc, input logic comp, input logic ill);
      chk({name, ".valid"}, {31'b0, instr_valid_o}, 32'd1);
      chk({name, ".instr"}, instr_o, ins);
      chk({name, ".raw"}, instr_raw_o, raw);
      chk({name, ".pc"}, pc_o, pc);
      chk({name, ".comp"}, {31'b0, is_compressed_o}, {31'b0, comp});
      chk({name, ".ill"}, {31'b0, illegal_c_o}, {31'b0, ill});
      chk({name, ".ferr"}, {31'b0, fetch_err_o}, 32'd0);
      instr_ready_i = 1'b1;
      @(negedge clk);
      instr_ready_i = 1'b0;
   endtask

   task automatic chk_idle(input string name);
      chk({name, ".valid"}, {31'b0, instr_valid_o}, 32'd0);
      chk({name, ".ready"}, {31'b0, fetch_ready_o}, 32'd1);
      chk({name, ".instr"}, instr_o, 32'd0);
      chk({name, ".raw"}, instr_raw_o, 32'd0);
      chk({name, ".pc"}, pc_o, 32'd0);
      chk({name, ".flags"}, {29'b0, is_compressed_o, illegal_c_o, fetch_err_o}, 32'd0);
   endtask

   initial begin
      set_vec(0, 1'b1, 32'h80, 32'h00A00093, 1,
              32'h00A00093, 32'h00A00093, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      set_vec(1, 1'b1, 32'h80, 32'h45054501, 2,
              32'h00000513, 32'h00004501, 32'h80, 1'b1, 1'b0, 32'h00100513, 32'h00004505, 32'h82, 1'b1, 1'b0);
      set_vec(2, 1'b1, 32'h80, 32'h00930001, 1,
              32'h00000013, 32'h00000001, 32'h80, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      set_vec(3, 1'b0, 32'h0, 32'h000100A0, 2,
              32'h00A00093, 32'h00A00093, 32'h82, 1'b0, 1'b0, 32'h00000013, 32'h00000001, 32'h86, 1'b1, 1'b0);
      set_vec(4, 1'b1, 32'h102, 32'h45010001, 1,
              32'h00000513, 32'h00004501, 32'h102, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      set_vec(5, 1'b0, 32'h0, 32'h00000000, 2,
              32'h0, 32'h0, 32'h104, 1'b1, 1'b1, 32'h0, 32'h0, 32'h106, 1'b1, 1'b1);
      set_vec(6, 1'b1, 32'h80, 32'h80824082, 2,
              32'h00012083, 32'h00004082, 32'h80, 1'b1, 1'b0, 32'h00008067, 32'h00008082, 32'h82, 1'b1, 1'b0);
      set_vec(7, 1'b1, 32'h80, 32'h90020040, 2,
              32'h00410413, 32'h00000040, 32'h80, 1'b1, 1'b0, 32'h00100073, 32'h00009002, 32'h82, 1'b1, 1'b0);
      set_vec(8, 1'b1, 32'h80, 32'h00018000, 2,
              32'h00008000, 32'h00008000, 32'h80, 1'b1, 1'b1, 32'h00000013, 32'h00000001, 32'h82, 1'b1, 1'b0);
      set_vec(9, 1'b1, 32'hFFFFFFFE, 32'h00010000, 1,
              32'h00000013, 32'h00000001, 32'hFFFFFFFE, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      set_vec(10, 1'b0, 32'h0, 32'h00A00093, 1,
              32'h00A00093, 32'h00A00093, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

      // Reset state, then boot address fetch without redirect
      repeat (3) @(negedge clk);
      chk_idle("rst_held");
      rst_ni = 1'b1;
      @(negedge clk);
      chk_idle("rst_rel");
      send_word("boot", 32'h00A00093, 1'b0);
      pop_check("boot.e0", 32'h00A00093, 32'h00A00093, 32'h80, 1'b0, 1'b0);

      // Vector table
      for (int i = 0; i < NVEC; i++) begin
         if (vecs[i].redir) begin
            do_redirect(vecs[i].raddr);
         end
         send_word($sformatf("v%0d", i), vecs[i].word, 1'b0);
         for (int k = 0; k < vecs[i].n; k++) begin
            pop_check($sformatf("v%0d.e%0d", i, k), vecs[i].e_instr[k], vecs[i].e_raw[k],
                      vecs[i].e_pc[k], vecs[i].e_comp[k], vecs[i].e_ill[k]);
         end
         chk($sformatf("v%0d.drained", i), {31'b0, instr_valid_o}, 32'd0);
`ifdef IBEX_REALIGN_PERF_EN
         if (i == 3) chk("v3.straddle_cnt", {16'b0, straddle_cnt_o}, 32'd1);
         if (i == 4) chk("v4.straddle_clr", {16'b0, straddle_cnt_o}, 32'd0);
`endif
      end

      // Backpressure: two entries fill DEPTH=2; ready returns only with two free
      do_redirect(32'h80);
      send_word("bp", 32'h45054501, 1'b0);
      chk("bp.ready_full", {31'b0, fetch_ready_o}, 32'd0);
      @(negedge clk);
      chk("bp.ready_hold", {31'b0, fetch_ready_o}, 32'd0);
      pop_check("bp.e0", 32'h00000513, 32'h00004501, 32'h80, 1'b1, 1'b0);
      chk("bp.ready_one_free", {31'b0, fetch_ready_o}, 32'd0);
      pop_check("bp.e1", 32'h00100513, 32'h00004505, 32'h82, 1'b1, 1'b0);
      chk("bp.ready_two_free", {31'b0, fetch_ready_o}, 32'd1);
      chk("bp.empty", {31'b0, instr_valid_o}, 32'd0);

      // Fetch error with residue held, then recovery by redirect
      do_redirect(32'h80);
      send_word("err.w0", 32'h00930001, 1'b0);
      pop_check("err.nop", 32'h00000013, 32'h00000001, 32'h80, 1'b1, 1'b0);
      send_word("err.w1", 32'h12345678, 1'b1);
      chk("err.valid", {31'b0, instr_valid_o}, 32'd1);
      chk("err.ferr", {31'b0, fetch_err_o}, 32'd1);
      chk("err.pc", pc_o, 32'h82);
      chk("err.ready", {31'b0, fetch_ready_o}, 32'd0);
      fetch_valid_i = 1'b1;
      fetch_rdata_i = 32'h00A00093;
      @(negedge clk);
      fetch_valid_i = 1'b0;
      chk("err.stuck_ready", {31'b0, fetch_ready_o}, 32'd0);
      chk("err.stuck_ferr", {31'b0, fetch_err_o}, 32'd1);
      do_redirect(32'h200);
      chk("err.redir_valid", {31'b0, instr_valid_o}, 32'd0);
      chk("err.redir_ready", {31'b0, fetch_ready_o}, 32'd1);
      send_word("err.w2", 32'h00A00093, 1'b0);
      pop_check("err.after", 32'h00A00093, 32'h00A00093, 32'h200, 1'b0, 1'b0);

      // Asynchronous reset in the middle of a cycle clears the queue immediately
      do_redirect(32'h300);
      send_word("arst", 32'h45054501, 1'b0);
      chk("arst.pre_valid", {31'b0, instr_valid_o}, 32'd1);
      #2;
      rst_ni = 1'b0;
      #1;
      chk("arst.valid", {31'b0, instr_valid_o}, 32'd0);
      chk("arst.ready", {31'b0, fetch_ready_o}, 32'd1);
      @(negedge clk);
      rst_ni = 1'b1;
      send_word("arst.boot", 32'h00A00093, 1'b0);
      pop_check("arst.e0", 32'h00A00093, 32'h00A00093, 32'h80, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
